reg_file_2r1w: RTL

//  Parametrised register file: NREGS words of WIDTH bits, two independent read ports,
//  one write port. Successor to the single-bit cell: storage rows with write-through bypass
//  and a per-register busy scoreboard.

---
 rtl/reg_file_2r1w_pkg.sv | 19 +
 rtl/reg_file_2r1w_if.sv | 44 ++++
 rtl/reg_file_2r1w_word.sv | 26 ++
 rtl/reg_file_2r1w.sv | 105 ++++++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Shared defaults and helpers for the two-read/one-write register file.
// The default geometry and zero-register behaviour live here so every file
// of the register file agrees on them.
package reg_file_2r1w_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NREGS    = 16;
  localparam int DEF_AW       = 4;
  localparam int DEF_ZERO_REG = 1;

  // An address names real, writable storage only if it is inside the array
  // and is not the hardwired zero register.
  function automatic bit addrValid(input int unsigned addr,
                                   input int unsigned nregs,
                                   input bit          zeroReg);
    return (addr < nregs) && !(zeroReg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the register file: one write port, two read ports with
// busy flags, and the reservation port used by the issue logic.
interface reg_file_2r1w_if
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic             rd_en1;
  logic [AW-1:0]    rd_addr1;
  logic [WIDTH-1:0] rd_data1;
  logic             rd_busy1;

  logic             rd_en2;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data2;
  logic             rd_busy2;

  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_conflict;

  // Datapath side: drives writes, read addresses and reservations.
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en1, rd_addr1, rd_en2, rd_addr2,
    output rsv_en, rsv_addr,
    input  rd_data1, rd_busy1, rd_data2, rd_busy2, rsv_conflict
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en1, rd_addr1, rd_en2, rd_addr2,
    input  rsv_en, rsv_addr,
    output rd_data1, rd_busy1, rd_data2, rd_busy2, rsv_conflict
  );

endinterface

// File: rtl/reg_file_2r1w_word.sv
// One storage row of the register file: a WIDTH-bit word that loads on its
// write enable and clears asynchronously with the file reset.
module reg_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Hold the word, replacing it only when this row is selected for a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Decode-stage register file: NREGS x WIDTH storage, two combinational read
// ports with write-through bypass, and a per-register busy scoreboard that
// tracks producers in flight so the hazard logic can stall consumers.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NREGS    = DEF_NREGS,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic             clk,
  input logic             rst_n,
  reg_file_2r1w_if.slave  bus
);

  localparam bit ZeroRegOn = (ZERO_REG != 0);

  logic [WIDTH-1:0] words [NREGS];
  logic [NREGS-1:0] wordWe;
  logic             wrValid;
  logic             rsvValid;

  logic             rdEn   [2];
  logic [AW-1:0]    rdAddr [2];
  logic [WIDTH-1:0] rdData [2];
  logic             rdBusy [2];

  logic [NREGS-1:0] busy_q, busy_d;
  logic             rsvConflict_q, rsvConflict_d;

  assign wrValid  = bus.wr_en  && addrValid(32'(bus.wr_addr),  NREGS, ZeroRegOn);
  assign rsvValid = bus.rsv_en && addrValid(32'(bus.rsv_addr), NREGS, ZeroRegOn);

  // Write decoder feeding one storage row per register.
  for (genvar i = 0; i < NREGS; i++) begin : g_row
    assign wordWe[i] = wrValid && (32'(bus.wr_addr) == i);

    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we_i  (wordWe[i]),
      .d_i   (bus.wr_data),
      .q_o   (words[i])
    );
  end

  assign rdEn[0]   = bus.rd_en1;
  assign rdAddr[0] = bus.rd_addr1;
  assign rdEn[1]   = bus.rd_en2;
  assign rdAddr[1] = bus.rd_addr2;

  // Read muxes: a same-cycle write to the read address is forwarded and also
  // resolves the hazard, so busy is only reported when reading stored data.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = '0;
      rdBusy[p] = 1'b0;
      if (rdEn[p] && addrValid(32'(rdAddr[p]), NREGS, ZeroRegOn)) begin
        if (wrValid && (bus.wr_addr == rdAddr[p])) begin
          rdData[p] = bus.wr_data;
        end else begin
          for (int i = 0; i < NREGS; i++) begin
            if (32'(rdAddr[p]) == i) begin
              rdData[p] = words[i];
              rdBusy[p] = busy_q[i];
            end
          end
        end
      end
    end
  end

  // Outputs are forced low while reset is held, even if a write is presented.
  assign bus.rd_data1     = rst_n ? rdData[0] : '0;
  assign bus.rd_busy1     = rst_n & rdBusy[0];
  assign bus.rd_data2     = rst_n ? rdData[1] : '0;
  assign bus.rd_busy2     = rst_n & rdBusy[1];
  assign bus.rsv_conflict = rsvConflict_q;

  // Scoreboard update: writes retire producers, reservations add new ones, and
  // a new producer wins over a write retiring the old one in the same cycle.
  always_comb begin
    busy_d        = busy_q & ~wordWe;
    rsvConflict_d = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rsvValid && (32'(bus.rsv_addr) == i)) begin
        rsvConflict_d = busy_q[i] && !wordWe[i];
        busy_d[i]     = 1'b1;
      end
    end
  end

  // Busy vector and one-cycle conflict pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      rsvConflict_q <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      rsvConflict_q <= rsvConflict_d;
    end
  end

endmodule
